// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // IDLE: no producer holds the write port. OWN: the owner register is locked.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Width of an index able to address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat counter that must be able to hold burst_max itself.
    function automatic int cnt_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals around the write-port arbiter.
//
// Handshake: producer i offers a beat with req_valid_i[i]; the beat is taken in
// the cycle where req_valid_i[i] & req_ready_o[i] is high at the clock edge.
// While valid is high and ready is low, req_data_i and req_last_i must stay
// stable. Ready may depend combinationally on valid. On the FIFO side a write
// happens on every edge with fifo_we_o high; fifo_we_o is never high while
// fifo_full_i is high.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32
);
    import fifo_arb_pkg::*;

    localparam int IW = idx_width(N_REQ);

    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_last_i;
    logic [N_REQ*WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]       fifo_wdata_o;
    logic                   fifo_we_o;
    logic                   fifo_full_i;
    logic [IW-1:0]          owner_o;
    logic                   busy_o;

    // Producers plus FIFO model (drives requests and full, observes the rest).
    modport master (
        output req_valid_i, req_last_i, req_data_i, fifo_full_i,
        input  req_ready_o, fifo_wdata_o, fifo_we_o, owner_o, busy_o
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_i, req_last_i, req_data_i, fifo_full_i,
        output req_ready_o, fifo_wdata_o, fifo_we_o, owner_o, busy_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: first set request at or after start.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    // One extra bit so start+i can exceed N before the wrap is applied.
    logic [IW:0] cand;

    // Walk the requesters from start, wrapping once, and keep the first hit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, start} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one sync_fifo write port between N_REQ producers with round-robin
// grants that last up to BURST_MAX beats or until the packet's last beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = cnt_width(BURST_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] last;
    logic [N_REQ-1:0] ready;
    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [IW-1:0]    start;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic [IW-1:0]    sel;
    logic             active;
    logic             we;
    logic [WIDTH-1:0] wdata;

    assign valid = bus.req_valid_i;
    assign last  = bus.req_last_i;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data_i[g*WIDTH +: WIDTH];
    end

    // The search starts one past the last owner, so the previous winner ranks last.
    assign start = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (valid),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Zero-latency transfer path: select a producer and forward its beat when the FIFO has room.
    always_comb begin
        sel    = (state_q == OWN) ? owner_q : pick_idx;
        active = rst_ni && ((state_q == OWN) || pick_found) && !bus.fifo_full_i;
        ready  = '0;
        if (active) begin
            ready[sel] = 1'b1;
        end
        we    = active && valid[sel];
        wdata = we ? data_arr[sel] : '0;
    end

    // Grant bookkeeping: lock on the first beat, release on last, burst limit or a gap.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (we) begin
                    owner_d = sel;
                    rr_d    = sel;
                    count_d = CW'(1);
                    if (!(last[sel] || (BURST_MAX == 1))) begin
                        state_d = OWN;
                    end
                end
            end
            OWN: begin
                if (we) begin
                    count_d = count_q + 1'b1;
                    if (last[owner_q] || (int'(count_q) + 1 == BURST_MAX)) begin
                        state_d = IDLE;
                    end
                end else if (!valid[owner_q]) begin
                    // An owner that stops offering beats gives up the port at once;
                    // a stall caused only by full keeps the grant.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset; rr starts at the top index so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= LAST_IDX;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.fifo_we_o    = we;
    assign bus.fifo_wdata_o = wdata;
    assign bus.owner_o      = owner_q;
    assign bus.busy_o       = (state_q == OWN);

    // A producer stalled with valid high must keep its data and last flag unchanged.
    for (genvar g = 0; g < N_REQ; g++) begin : g_hold_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            ($past(rst_ni) && $past(valid[g] && !ready[g]) && valid[g])
            |-> ((data_arr[g] == $past(data_arr[g])) && (last[g] == $past(last[g]))));
    end

    // The FIFO is never written while it reports full.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(we && bus.fifo_full_i));

endmodule
